mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the instruction-fetch side (I, read-only) and the load/store side (D, read/write).
- Requests are accepted with a valid/ready handshake and routed to the memory one at a time. The read data or write completion is returned to the owning requester.
- A per-transaction timeout counter converts a hung memory into an error response, so the pipeline never deadlocks.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).
- TIMEOUT, 16, max cycles waiting for mem_ready before aborting; must be ≥ 2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_req_valid  input  1  fetch request
- i_req_addr  input  ADDR_W  fetch byte address
- i_req_ready  output  1  fetch request accepted this cycle
- i_resp_valid  output  1  one-cycle fetch response pulse
- i_resp_data  output  DATA_W  fetched word
- i_resp_err  output  1  fetch timed out
- d_req_valid  input  1  load/store request
- d_req_we  input  1  1 = store
- d_req_be  input  4  store byte enables
- d_req_addr  input  ADDR_W  byte address
- d_req_wdata  input  DATA_W  store data
- d_req_ready  output  1  load/store request accepted
- d_resp_valid  output  1  one-cycle load/store response pulse
- d_resp_data  output  DATA_W  load data (0 for stores)
- d_resp_err  output  1  misaligned access or timeout
- mem_req  output  1  memory access strobe, held until mem_ready
- mem_we  output  1  write enable
- mem_be  output  4  byte enables
- mem_addr  output  ADDR_W  word-aligned address
- mem_wdata  output  DATA_W  write data
- mem_ready  input  1  memory completes access; mem_rdata valid this cycle
- mem_rdata  input  DATA_W  read data

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; all outputs 0.
  - last_grant resets to D, so I wins the first tie.
  - Timeout counter resets to 0.
  - Reset mid-transaction abandons it; no response is issued.
- States:
  - IDLE → BUSY on a grant.
  - BUSY → RESP on mem_ready or timeout.
  - RESP → IDLE after one cycle.
- Grant (IDLE only):
  - Only one valid request: grant it.
  - Both valid: grant the side not equal to last_grant (round-robin).
  - Grant cycle: the winner's *_req_ready = 1 for exactly that cycle, and the request fields are latched.
  - *_req_ready is 0 in BUSY and RESP. A request not granted must be held by its requester.
- Alignment:
  - I-side mem_addr = i_req_addr & ~3; mem_be = 4'hF, mem_we = 0.
  - D-side mem_addr = d_req_addr & ~3.
  - D-side with addr[1:0] ≠ 0 is a misaligned access. It is accepted but not issued: go directly IDLE → RESP with d_resp_err = 1 and d_resp_data = 0. last_grant is still updated.
- BUSY:
  - mem_req = 1 with the latched fields stable.
  - Counter increments each cycle.
  - mem_ready in the first BUSY cycle is legal, so minimum latency is grant → response 2 cycles.
  - mem_rdata is captured on mem_ready.
  - If the counter reaches TIMEOUT − 1 without mem_ready: deassert mem_req, go to RESP, err = 1, data = 0.
  - mem_ready in the same cycle as the timeout: mem_ready wins and there is no error.
- RESP:
  - The owner's *_resp_valid = 1 for one cycle with data/err.
  - The other side's resp signals stay 0.
  - Counter clears.
  - The next grant can occur at the earliest in the cycle after RESP (back-to-back throughput: one transaction per 3 cycles minimum).
- mem_ready outside BUSY is ignored.
- Responses are always in grant order; there is at most one outstanding transaction.

Decomposition:
- Package mem_arb_pkg:
  - typedef arb_state_t {IDLE, BUSY, RESP}
  - typedef requester_t {REQ_I, REQ_D}
  - constant WORD_ALIGN_MASK = 32'hFFFF_FFFC
- Sub-module rr_arbiter2:
  - Two-input round-robin grant with a last_grant register, updated on accept.
  - Reused by later cache/DMA arbitration.

Test Plan:
1. Single fetch: i_req_valid = 1, addr = 0x00000006, mem_ready after 3 BUSY cycles with rdata = 0xDEADBEEF → mem_addr = 0x00000004, mem_be = F; i_resp_valid pulse with data = 0xDEADBEEF, err = 0.
2. Simultaneous I and D requests sustained for 4 transactions after reset → grant order I, D, I, D; each response goes only to its owner.
3. Store: d_req_we = 1, be = 4'b0011, addr = 0x10, wdata = 0x12345678, mem_ready in the first BUSY cycle → mem_we = 1, mem_be = 3; d_resp_valid 2 cycles after grant, data = 0.
4. Misaligned load at addr = 0x13 → mem_req never asserted; d_resp_valid with err = 1 in the cycle after grant.
5. mem_ready never asserted, TIMEOUT = 16 → mem_req high exactly 16 cycles, then *_resp_err = 1; the arbiter returns to IDLE and the next request is served normally.
6. Reset asserted in BUSY → next cycle all outputs 0, no response pulse; a subsequent fetch completes correctly.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Imported by the arbiter top and its round-robin helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; last_grant moves to the winner on accept.
// Grants only while en is high, so an accept is simply any grant.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

    requester_t last_q;
    requester_t last_d;

    always_comb begin
        gnt_i  = 1'b0;
        gnt_d  = 1'b0;
        last_d = last_q;
        if (en) begin
            if (req_i && (!req_d || last_q == REQ_D)) begin
                gnt_i = 1'b1;
            end else if (req_d) begin
                gnt_d = 1'b1;
            end
        end
        if (gnt_i) begin
            last_d = REQ_I;
        end else if (gnt_d) begin
            last_d = REQ_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and load/store (D),
// one transaction at a time, with a timeout that turns a hang into an error.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,
    output logic              i_resp_err,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [3:0]        d_req_be,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic              d_resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(~WORD_ALIGN_MASK);

    arb_state_t        state_q, state_d;
    requester_t        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic arb_en;
    logic gnt_i;
    logic gnt_d;
    logic busy;
    logic resp;

    assign arb_en = (state_q == IDLE) && !reset;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req_i (i_req_valid),
        .req_d (d_req_valid),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gnt_i) begin
                    owner_d = REQ_I;
                    addr_d  = i_req_addr & ALIGN_MASK;
                    we_d    = 1'b0;
                    be_d    = 4'hF;
                    wdata_d = '0;
                    err_d   = 1'b0;
                    state_d = BUSY;
                end else if (gnt_d) begin
                    owner_d = REQ_D;
                    addr_d  = d_req_addr & ALIGN_MASK;
                    we_d    = d_req_we;
                    be_d    = d_req_be;
                    wdata_d = d_req_wdata;
                    err_d   = 1'b0;
                    state_d = BUSY;
                    // Misaligned: answered with an error, never issued.
                    if (d_req_addr[1:0] != 2'b00) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= REQ_I;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign resp = (state_q == RESP);

    assign i_req_ready = gnt_i;
    assign d_req_ready = gnt_d;

    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_be    = busy ? be_q : 4'h0;
    assign mem_addr  = busy ? addr_q : '0;
    assign mem_wdata = busy ? wdata_q : '0;

    assign i_resp_valid = resp && (owner_q == REQ_I);
    assign i_resp_data  = i_resp_valid ? rdata_q : '0;
    assign i_resp_err   = i_resp_valid & err_q;

    assign d_resp_valid = resp && (owner_q == REQ_D);
    assign d_resp_data  = d_resp_valid ? rdata_q : '0;
    assign d_resp_err   = d_resp_valid & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, round-robin, store,
// misaligned access, timeout and mid-transaction reset.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ready;
    logic        i_resp_valid;
    logic [31:0] i_resp_data;
    logic        i_resp_err;
    logic        d_req_valid;
    logic        d_req_we;
    logic [3:0]  d_req_be;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        d_resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int nvec;
    int nerr;
    int n;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .i_req_addr   (i_req_addr),
        .i_req_ready  (i_req_ready),
        .i_resp_valid (i_resp_valid),
        .i_resp_data  (i_resp_data),
        .i_resp_err   (i_resp_err),
        .d_req_valid  (d_req_valid),
        .d_req_we     (d_req_we),
        .d_req_be     (d_req_be),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_req_ready  (d_req_ready),
        .d_resp_valid (d_resp_valid),
        .d_resp_data  (d_resp_data),
        .d_resp_err   (d_resp_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_iready"}, 32'(i_req_ready), 32'd0);
        chk({tag, "_dready"}, 32'(d_req_ready), 32'd0);
        chk({tag, "_ivalid"}, 32'(i_resp_valid), 32'd0);
        chk({tag, "_dvalid"}, 32'(d_resp_valid), 32'd0);
        chk({tag, "_mreq"}, 32'(mem_req), 32'd0);
        chk({tag, "_maddr"}, mem_addr, 32'd0);
        chk({tag, "_mbe"}, 32'(mem_be), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nvec        = 0;
        nerr        = 0;
        reset       = 1'b1;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        d_req_be    = 4'h0;
        d_req_addr  = '0;
        d_req_wdata = '0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick();

        // Single fetch, unaligned byte address, ready in 3rd BUSY cycle
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0006;
        #1;
        chk("t1_iready", 32'(i_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0;
        #1;
        chk("t1_mreq", 32'(mem_req), 32'd1);
        chk("t1_maddr", mem_addr, 32'h0000_0004);
        chk("t1_mbe", 32'(mem_be), 32'hF);
        chk("t1_mwe", 32'(mem_we), 32'd0);
        chk("t1_iready_busy", 32'(i_req_ready), 32'd0);
        tick();
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
        chk("t1_ivalid", 32'(i_resp_valid), 32'd1);
        chk("t1_idata", i_resp_data, 32'hDEAD_BEEF);
        chk("t1_ierr", 32'(i_resp_err), 32'd0);
        chk("t1_dvalid", 32'(d_resp_valid), 32'd0);
        chk("t1_mreq_resp", 32'(mem_req), 32'd0);
        tick();
        chk("t1_ivalid_off", 32'(i_resp_valid), 32'd0);

        // Fresh reset, then I and D both held: grants alternate I, D, I, D
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0040;
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_be    = 4'hF;
        d_req_addr  = 32'h0000_0020;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_iready%0d", k), 32'(i_req_ready),
                (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t2_dready%0d", k), 32'(d_req_ready),
                (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            mem_ready = 1'b1;
            mem_rdata = 32'h0000_1000 + 32'(k);
            #1;
            chk($sformatf("t2_maddr%0d", k), mem_addr,
                (k % 2 == 0) ? 32'h40 : 32'h20);
            chk($sformatf("t2_rdy_busy%0d", k),
                32'({i_req_ready, d_req_ready}), 32'd0);
            tick();
            mem_ready = 1'b0;
            mem_rdata = 32'hFFFF_FFFF;
            #1;
            chk($sformatf("t2_ivalid%0d", k), 32'(i_resp_valid),
                (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t2_dvalid%0d", k), 32'(d_resp_valid),
                (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("t2_data%0d", k),
                (k % 2 == 0) ? i_resp_data : d_resp_data,
                32'h0000_1000 + 32'(k));
            chk($sformatf("t2_idle_data%0d", k),
                (k % 2 == 0) ? d_resp_data : i_resp_data, 32'd0);
            tick();
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        mem_rdata   = '0;

        // Store with ready in the first BUSY cycle
        d_req_valid = 1'b1;
        d_req_we    = 1'b1;
        d_req_be    = 4'b0011;
        d_req_addr  = 32'h0000_0010;
        d_req_wdata = 32'h1234_5678;
        #1;
        chk("t3_dready", 32'(d_req_ready), 32'd1);
        tick();
        d_req_valid = 1'b0;
        mem_ready   = 1'b1;
        mem_rdata   = 32'h5555_AAAA;
        #1;
        chk("t3_mwe", 32'(mem_we), 32'd1);
        chk("t3_mbe", 32'(mem_be), 32'h3);
        chk("t3_maddr", mem_addr, 32'h10);
        chk("t3_mwdata", mem_wdata, 32'h1234_5678);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("t3_dvalid", 32'(d_resp_valid), 32'd1);
        chk("t3_ddata", d_resp_data, 32'd0);
        chk("t3_derr", 32'(d_resp_err), 32'd0);
        chk("t3_ivalid", 32'(i_resp_valid), 32'd0);
        tick();

        // Misaligned load: no memory access, error in the next cycle
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        d_req_be    = 4'hF;
        d_req_addr  = 32'h0000_0013;
        #1;
        chk("t4_dready", 32'(d_req_ready), 32'd1);
        chk("t4_mreq_g", 32'(mem_req), 32'd0);
        tick();
        d_req_valid = 1'b0;
        #1;
        chk("t4_mreq", 32'(mem_req), 32'd0);
        chk("t4_dvalid", 32'(d_resp_valid), 32'd1);
        chk("t4_derr", 32'(d_resp_err), 32'd1);
        chk("t4_ddata", d_resp_data, 32'd0);
        tick();
        chk("t4_dvalid_off", 32'(d_resp_valid), 32'd0);

        // mem_ready while idle must not produce a response
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_1111;
        tick();
        mem_ready = 1'b0;
        #1;
        chk("idle_rdy", 32'({i_resp_valid, d_resp_valid}), 32'd0);

        // Timeout: mem_req held exactly 16 cycles, then an error response
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0080;
        #1;
        chk("t5_iready", 32'(i_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("t5_req_cycles", 32'(n), 32'd16);
        chk("t5_ivalid", 32'(i_resp_valid), 32'd1);
        chk("t5_ierr", 32'(i_resp_err), 32'd1);
        chk("t5_idata", i_resp_data, 32'd0);
        tick();
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0084;
        #1;
        chk("t5b_iready", 32'(i_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0;
        mem_ready   = 1'b1;
        mem_rdata   = 32'hCAFE_F00D;
        #1;
        chk("t5b_maddr", mem_addr, 32'h84);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("t5b_ivalid", 32'(i_resp_valid), 32'd1);
        chk("t5b_idata", i_resp_data, 32'hCAFE_F00D);
        chk("t5b_ierr", 32'(i_resp_err), 32'd0);
        tick();

        // Reset in BUSY abandons the transaction
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0100;
        tick();
        i_req_valid = 1'b0;
        #1;
        chk("t6_mreq", 32'(mem_req), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        chk_all_zero("t6_rst");
        reset     = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #1;
        chk_all_zero("t6_after");
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0104;
        #1;
        chk("t6_iready", 32'(i_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0;
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        #1;
        chk("t6_maddr", mem_addr, 32'h104);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("t6_ivalid", 32'(i_resp_valid), 32'd1);
        chk("t6_idata", i_resp_data, 32'h0BAD_F00D);
        chk("t6_ierr", 32'(i_resp_err), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
